// File: rtl/prog_loader.sv
// Program loader: streams an image into memory with the core held in reset, optionally
// verifies it by read-back checksum, then releases the core and pulses trigger_program.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module prog_loader #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int REG_WIDTH  = `REG_WIDTH,
  parameter bit VERIFY     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  in_valid,
  input  logic [REG_WIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  core_reset_n,
  output logic                  trigger_program,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [REG_WIDTH-1:0]  checksum
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WRITE   = 4'd1;
  localparam logic [3:0] ST_DRAIN   = 4'd2;
  localparam logic [3:0] ST_VERIFY  = 4'd3;
  localparam logic [3:0] ST_CMP     = 4'd4;
  localparam logic [3:0] ST_RELEASE = 4'd5;
  localparam logic [3:0] ST_TRIGGER = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;
  localparam logic [3:0] ST_ERROR   = 4'd8;

  logic [3:0]            state;
  logic [ADDR_WIDTH-1:0] base_q, len_q, cnt;
  logic [REG_WIDTH-1:0]  rsum;
  logic                  idle_like, start_acc, hs;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign start_acc = start && idle_like;
  assign in_ready  = (state == ST_WRITE);
  assign hs        = in_valid && in_ready;
  assign busy      = !idle_like;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      cnt             <= '0;
      rsum            <= '0;
      checksum        <= '0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= '0;
      core_reset_n    <= 1'b0;
      trigger_program <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      // Status outputs are registered decodes of the state, one cycle behind it.
      mem_we          <= hs;
      trigger_program <= (state == ST_TRIGGER);
      done            <= (state == ST_DONE) && !start_acc;
      error           <= (state == ST_ERROR) && !start_acc;
      if (start_acc)
        core_reset_n <= 1'b0;
      else if (state == ST_RELEASE)
        core_reset_n <= 1'b1;

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_acc) begin
            base_q   <= base_addr;
            len_q    <= length;
            cnt      <= '0;
            checksum <= '0;
            rsum     <= '0;
            state    <= (length == '0) ? ST_RELEASE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (hs) begin
            mem_addr <= base_q + cnt;
            mem_din  <= in_data;
            checksum <= checksum + in_data;
            cnt      <= cnt + 1'b1;
            if (cnt == len_q - 1'b1)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Preload the first read address so each VERIFY cycle has one in flight.
          cnt      <= '0;
          mem_addr <= base_q;
          state    <= VERIFY ? ST_VERIFY : ST_RELEASE;
        end
        ST_VERIFY: begin
          if (cnt != '0)
            rsum <= rsum + mem_dout;
          mem_addr <= base_q + cnt + 1'b1;
          cnt      <= cnt + 1'b1;
          if (cnt == len_q)
            state <= ST_CMP;
        end
        ST_CMP:     state <= (rsum == checksum) ? ST_RELEASE : ST_ERROR;
        ST_RELEASE: state <= ST_TRIGGER;
        ST_TRIGGER: state <= ST_DONE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: basic, backpressure, corruption, empty, wrap and reset-mid-write.
module tb_prog_loader;
  localparam int AW = 16;
  localparam int RW = 8;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] base_addr = '0, length = '0;
  logic [RW-1:0] in_data = '0;
  logic          in_ready, mem_we, core_reset_n, trigger_program, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_din, mem_dout, checksum;

  logic [RW-1:0] mem [0:65535];
  logic          corrupt = 1'b0;
  logic          wrote40 = 1'b0;

  int checks = 0, errors = 0;
  int edge_n = 0, start_e = 0;
  int we_cnt = 0, rdy_cnt = 0, trig_cnt = 0;
  int crn_edge = -1, trig_edge = -1, done_edge = -1;

  prog_loader #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .VERIFY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .core_reset_n(core_reset_n),
    .trigger_program(trigger_program), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Synchronous memory with one-cycle read latency; optional corruption of 0x13 on read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    if (mem_we && mem_addr == 16'h0040) wrote40 <= 1'b1;
    mem_dout <= (corrupt && mem_addr == 16'h0013) ? 8'h03 : mem[mem_addr];
  end

  // A value seen here is what a downstream flop captures on the next edge,
  // so rise edges are reported relative to the start edge (edge 0).
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (in_ready) rdy_cnt++;
    if (trigger_program) trig_cnt++;
    if (core_reset_n && crn_edge < 0) crn_edge = edge_n - start_e;
    if (trigger_program && trig_edge < 0) trig_edge = edge_n - start_e;
    if (done && done_edge < 0) done_edge = edge_n - start_e;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l; start_e = edge_n;
    @(posedge clk); #1;
    start = 1'b0;
    we_cnt = 0; rdy_cnt = 0; trig_cnt = 0;
    crn_edge = -1; trig_edge = -1; done_edge = -1;
  endtask

  task automatic stream(input logic [31:0] bytes, input int n, input bit gap, input bit poke);
    int i = 0;
    int k = 0;
    while (i < n && k < 50) begin
      @(negedge clk);
      in_valid = !(gap && (k % 2 == 1));
      in_data  = bytes[8*i +: 8];
      start    = poke && (i == 1);
      if (poke) base_addr = 16'h0040;
      if (in_valid && in_ready) i++;
      k++;
    end
    chk("stream_accepted", i, n);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_end", {31'd0, done | error}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_trigger", trigger_program, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", checksum, 0);
    reset_n = 1'b1;

    // Basic full-rate load
    start_load(16'h0010, 16'd4);
    chk("basic_busy", busy, 1);
    chk("basic_in_ready", in_ready, 1);
    chk("basic_core_held", core_reset_n, 0);
    stream(32'h028504A9, 4, 1'b0, 1'b0);
    wait_end(60);
    chk("basic_done", done, 1);
    chk("basic_error", error, 0);
    chk("basic_checksum", checksum, 32'h34);
    chk("basic_mem", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'h028504A9);
    chk("basic_crn_edge", crn_edge, 13);
    chk("basic_trig_edge", trig_edge, 14);
    chk("basic_done_edge", done_edge, 15);
    chk("basic_trig_cnt", trig_cnt, 1);
    chk("basic_we_cnt", we_cnt, 4);
    chk("basic_core_run", core_reset_n, 1);
    chk("basic_idle", busy, 0);

    // Backpressure: valid toggles, three idle cycles
    start_load(16'h0050, 16'd4);
    chk("bp_done_cleared", done, 0);
    stream(32'h028504A9, 4, 1'b1, 1'b0);
    wait_end(60);
    chk("bp_done", done, 1);
    chk("bp_mem", {mem[16'h53], mem[16'h52], mem[16'h51], mem[16'h50]}, 32'h028504A9);
    chk("bp_we_cnt", we_cnt, 4);
    chk("bp_crn_edge", crn_edge, 16);
    chk("bp_trig_edge", trig_edge, 17);
    chk("bp_done_edge", done_edge, 18);

    // Corruption during read-back
    corrupt = 1'b1;
    start_load(16'h0010, 16'd4);
    stream(32'h028504A9, 4, 1'b0, 1'b0);
    wait_end(60);
    repeat (5) @(negedge clk);
    chk("cor_error", error, 1);
    chk("cor_done", done, 0);
    chk("cor_core_held", core_reset_n, 0);
    chk("cor_crn_edge", crn_edge, -1);
    chk("cor_trig_cnt", trig_cnt, 0);
    chk("cor_checksum", checksum, 32'h34);
    corrupt = 1'b0;
    start_load(16'h0010, 16'd4);
    chk("cor_error_cleared", error, 0);
    stream(32'h028504A9, 4, 1'b0, 1'b0);
    wait_end(60);
    chk("cor_retry_done", done, 1);
    chk("cor_retry_error", error, 0);

    // Empty load
    start_load(16'h0030, 16'd0);
    wait_end(20);
    chk("empty_done", done, 1);
    chk("empty_crn_edge", crn_edge, 2);
    chk("empty_trig_edge", trig_edge, 3);
    chk("empty_done_edge", done_edge, 4);
    chk("empty_we_cnt", we_cnt, 0);
    chk("empty_rdy_cnt", rdy_cnt, 0);
    chk("empty_trig_cnt", trig_cnt, 1);

    // Address wrap
    start_load(16'hFFFE, 16'd4);
    stream(32'h44332211, 4, 1'b0, 1'b0);
    wait_end(60);
    chk("wrap_done", done, 1);
    chk("wrap_error", error, 0);
    chk("wrap_mem", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]}, 32'h44332211);
    chk("wrap_checksum", checksum, 32'hAA);

    // Reset mid-write, then a clean load with a start poked during WRITE
    start_load(16'h0020, 16'd4);
    stream(32'h0D0C0B0A, 2, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rmw_in_ready", in_ready, 0);
    chk("rmw_mem_we", mem_we, 0);
    chk("rmw_busy", busy, 0);
    chk("rmw_core_reset_n", core_reset_n, 0);
    chk("rmw_checksum", checksum, 0);
    chk("rmw_mem_addr", mem_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    start_load(16'h0020, 16'd4);
    stream(32'h0D0C0B0A, 4, 1'b0, 1'b1);
    wait_end(60);
    chk("rmw_done", done, 1);
    chk("rmw_mem", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'h0D0C0B0A);
    chk("rmw_checksum_final", checksum, 32'h2E);
    chk("rmw_crn_edge", crn_edge, 13);
    chk("rmw_we_cnt", we_cnt, 4);
    chk("rmw_no_restart", wrote40, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
